// File: rtl/eth_types_pkg.sv
// Shared header widths, protocol constants, parser states and byte helpers.
package eth_types_pkg;

  localparam int MAC_W  = 48;
  localparam int IP_W   = 32;
  localparam int PORT_W = 16;
  localparam int LEN_W  = 16;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

  localparam logic [5:0] ETH_HDR_LEN = 6'd14;
  localparam logic [5:0] IP_HDR_LEN  = 6'd20;
  localparam logic [5:0] UDP_HDR_LEN = 6'd8;

  typedef enum logic [2:0] {
    IDLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    DISCARD
  } rx_state_e;

  // Big-endian byte idx (0 = most significant) of a MAC address.
  function automatic logic [7:0] mac_byte(input logic [MAC_W-1:0] mac, input logic [2:0] idx);
    logic [MAC_W-1:0] s;
    s = mac << {idx, 3'b000};
    return s[MAC_W-1 -: 8];
  endfunction

  // Big-endian byte idx (0 = most significant) of an IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [IP_W-1:0] ip, input logic [1:0] idx);
    logic [IP_W-1:0] s;
    s = ip << {idx, 3'b000};
    return s[IP_W-1 -: 8];
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Streaming 16-bit one's-complement accumulator fed one byte at a time.
// sum_incl is the running sum including the byte presented this cycle.
module ip_csum_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        add,
  input  logic        hi_byte,
  input  logic [7:0]  data,
  output logic [15:0] sum_incl
);

  logic [15:0] sum;
  logic [15:0] addend;
  logic [16:0] raw;

  // Place the byte in its word half and fold the carry back in.
  always_comb begin
    addend   = hi_byte ? {data, 8'h00} : {8'h00, data};
    raw      = {1'b0, sum} + {1'b0, addend};
    sum_incl = raw[15:0] + {15'd0, raw[16]};
  end

  // Running sum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= 16'h0000;
    end else if (clr) begin
      sum <= 16'h0000;
    end else if (add) begin
      sum <= sum_incl;
    end
  end

endmodule

// File: rtl/eth_udp_rx_parser.sv
// Byte-stream Ethernet/IPv4/UDP receive parser with payload forwarding.
//
// state   | meaning
// IDLE    | waiting for first byte of a frame (that byte is eth byte 0)
// ETH_HDR | checking dest MAC and ethertype, capturing src MAC
// IP_HDR  | checking IPv4 fields and header checksum, capturing src IP
// UDP_HDR | capturing ports and length
// PAYLOAD | forwarding udp_len-8 payload bytes
// DISCARD | dropping bytes until in_last
module eth_udp_rx_parser
  import eth_types_pkg::*;
#(
  parameter logic [MAC_W-1:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [IP_W-1:0]  LOCAL_IP  = 32'hC0A8_0164
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              hdr_valid,
  output logic [MAC_W-1:0]  src_mac,
  output logic [IP_W-1:0]   src_ip,
  output logic [PORT_W-1:0] src_port,
  output logic [PORT_W-1:0] dest_port,
  output logic [LEN_W-1:0]  udp_len,
  output logic [7:0]        pay_data,
  output logic              pay_valid,
  output logic              pay_last,
  output logic              drop,
  output logic              trunc
);

  rx_state_e         state, state_nxt, adv_state;
  logic [5:0]        cnt, cnt_nxt;
  logic              bad, bad_nxt;
  logic              miss_loc, miss_loc_nxt, miss_bc, miss_bc_nxt;
  logic [LEN_W-1:0]  pay_rem, pay_rem_nxt;
  logic              hdr_nxt, drop_nxt, trunc_nxt, pv_nxt, pl_nxt;
  logic              byte_bad, hdr_end, hdr_fail;
  logic [15:0]       csum;
  logic [MAC_W-1:0]  sh_mac;
  logic [IP_W-1:0]   sh_ip;
  logic [PORT_W-1:0] sh_sport, sh_dport;
  logic [LEN_W-1:0]  sh_len;

  ip_csum_acc u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (state != IP_HDR),
    .add      (in_valid && (state == IP_HDR)),
    .hi_byte  (~cnt[0]),
    .data     (in_data),
    .sum_incl (csum)
  );

  // Next-state, header verdicts and output pulses for the byte on the bus.
  always_comb begin
    state_nxt    = state;
    adv_state    = state;
    cnt_nxt      = cnt;
    bad_nxt      = bad;
    miss_loc_nxt = miss_loc;
    miss_bc_nxt  = miss_bc;
    pay_rem_nxt  = pay_rem;
    hdr_nxt      = 1'b0;
    drop_nxt     = 1'b0;
    trunc_nxt    = 1'b0;
    pv_nxt       = 1'b0;
    pl_nxt       = 1'b0;
    byte_bad     = 1'b0;
    hdr_end      = 1'b0;
    hdr_fail     = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          miss_loc_nxt = in_data != mac_byte(LOCAL_MAC, 3'd0);
          miss_bc_nxt  = in_data != 8'hFF;
          if (in_last) drop_nxt = 1'b1;
          else         state_nxt = ETH_HDR;
        end
        ETH_HDR: begin
          if (cnt < 6'd6) begin
            miss_loc_nxt = miss_loc | (in_data != mac_byte(LOCAL_MAC, cnt[2:0]));
            miss_bc_nxt  = miss_bc | (in_data != 8'hFF);
          end
          byte_bad  = ((cnt == 6'd12) && (in_data != ETHERTYPE_IPV4[15:8])) ||
                      ((cnt == 6'd13) && (in_data != ETHERTYPE_IPV4[7:0]));
          hdr_end   = cnt == ETH_HDR_LEN - 6'd1;
          hdr_fail  = bad | byte_bad | (miss_loc & miss_bc);
          adv_state = IP_HDR;
        end
        IP_HDR: begin
          case (cnt)
            6'd0:  byte_bad = in_data != 8'h45;
            6'd6:  byte_bad = in_data[5] | (|in_data[4:0]);
            6'd7:  byte_bad = in_data != 8'h00;
            6'd9:  byte_bad = in_data != IP_PROTO_UDP;
            6'd16, 6'd17, 6'd18, 6'd19:
                   byte_bad = in_data != ip_byte(LOCAL_IP, cnt[1:0]);
            default: byte_bad = 1'b0;
          endcase
          hdr_end   = cnt == IP_HDR_LEN - 6'd1;
          hdr_fail  = bad | byte_bad | (csum != 16'hFFFF);
          adv_state = UDP_HDR;
        end
        UDP_HDR: begin
          hdr_end   = cnt == UDP_HDR_LEN - 6'd1;
          hdr_fail  = sh_len < {10'd0, UDP_HDR_LEN};
          adv_state = PAYLOAD;
        end
        PAYLOAD: begin
          pv_nxt      = 1'b1;
          pl_nxt      = (pay_rem == 16'd1) | in_last;
          trunc_nxt   = in_last & (pay_rem != 16'd1);
          pay_rem_nxt = pay_rem - 16'd1;
          if (pay_rem == 16'd1) state_nxt = in_last ? IDLE : DISCARD;
          else if (in_last)     state_nxt = IDLE;
        end
        DISCARD: begin
          if (in_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase

      if (state inside {ETH_HDR, IP_HDR, UDP_HDR}) begin
        if ((state == UDP_HDR) && hdr_end && !hdr_fail) begin
          // Header accepted; zero-length payload or early end still reports it.
          hdr_nxt     = 1'b1;
          pay_rem_nxt = sh_len - {10'd0, UDP_HDR_LEN};
          if (sh_len == {10'd0, UDP_HDR_LEN}) begin
            state_nxt = in_last ? IDLE : DISCARD;
          end else if (in_last) begin
            trunc_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = PAYLOAD;
          end
        end else if (in_last || (hdr_end && hdr_fail)) begin
          drop_nxt  = 1'b1;
          state_nxt = in_last ? IDLE : DISCARD;
        end else if (hdr_end) begin
          state_nxt = adv_state;
        end
      end

      // Counter restarts on every state entry; the IDLE byte is eth byte 0.
      if ((state_nxt != state) || (state == IDLE)) begin
        cnt_nxt = ((state == IDLE) && (state_nxt == ETH_HDR)) ? 6'd1 : 6'd0;
        bad_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + 6'd1;
        bad_nxt = bad | byte_bad;
      end
    end
  end

  // FSM state, counters and registered control pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      bad       <= 1'b0;
      miss_loc  <= 1'b0;
      miss_bc   <= 1'b0;
      pay_rem   <= '0;
      hdr_valid <= 1'b0;
      drop      <= 1'b0;
      trunc     <= 1'b0;
      pay_valid <= 1'b0;
      pay_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bad       <= bad_nxt;
      miss_loc  <= miss_loc_nxt;
      miss_bc   <= miss_bc_nxt;
      pay_rem   <= pay_rem_nxt;
      hdr_valid <= hdr_nxt;
      drop      <= drop_nxt;
      trunc     <= trunc_nxt;
      pay_valid <= pv_nxt;
      pay_last  <= pl_nxt;
    end
  end

  // Shadow field capture while parsing; publish to outputs only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mac    <= '0;
      sh_ip     <= '0;
      sh_sport  <= '0;
      sh_dport  <= '0;
      sh_len    <= '0;
      src_mac   <= '0;
      src_ip    <= '0;
      src_port  <= '0;
      dest_port <= '0;
      udp_len   <= '0;
      pay_data  <= 8'h00;
    end else begin
      if (in_valid) begin
        case (state)
          ETH_HDR: if ((cnt >= 6'd6) && (cnt < 6'd12)) sh_mac <= {sh_mac[MAC_W-9:0], in_data};
          IP_HDR:  if ((cnt >= 6'd12) && (cnt < 6'd16)) sh_ip <= {sh_ip[IP_W-9:0], in_data};
          UDP_HDR: begin
            if (cnt < 6'd2)                         sh_sport <= {sh_sport[7:0], in_data};
            else if (cnt < 6'd4)                    sh_dport <= {sh_dport[7:0], in_data};
            else if (cnt < 6'd6)                    sh_len   <= {sh_len[7:0], in_data};
          end
          PAYLOAD: pay_data <= in_data;
          default: ;
        endcase
      end
      if (hdr_nxt) begin
        src_mac   <= sh_mac;
        src_ip    <= sh_ip;
        src_port  <= sh_sport;
        dest_port <= sh_dport;
        udp_len   <= sh_len;
      end
    end
  end

endmodule
